// File: rtl/rename_unit_nw_pkg.sv
// Shared defaults for the N-wide rename stage (lane width, register counts, free-list depth).
package rename_unit_nw_pkg;

  localparam int RENAME_WIDTH   = 2;
  localparam int REG_SEL        = 5;
  localparam int PHY_REG_SEL    = 6;
  localparam int ARCH_REG_CNT   = 32;
  localparam int PHY_REG_CNT    = 64;
  localparam int FREELIST_DEPTH = PHY_REG_CNT - ARCH_REG_CNT;

endpackage

// File: rtl/rename_unit_nw_freelist.sv
// rename_freelist: circular free list of physical regs with multi-pop (rename), multi-push (commit),
// a commit head marking the oldest uncommitted allocation, and restore to that head on flush.
module rename_freelist
  import rename_unit_nw_pkg::*;
#(
  parameter int WIDTH   = RENAME_WIDTH,
  parameter int PHY_SEL = PHY_REG_SEL,
  parameter int BASE    = ARCH_REG_CNT,
  parameter int DEPTH   = FREELIST_DEPTH,
  parameter int CNT_W   = PHY_REG_SEL + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CNT_W-1:0]         pop_cnt,
  input  logic [WIDTH-1:0]         push_valid,
  input  logic [WIDTH*PHY_SEL-1:0] push_pd,
  input  logic                     flush,
  output logic [WIDTH*PHY_SEL-1:0] pop_pd,
  output logic [CNT_W-1:0]         free_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DEPTH_U = DEPTH;
  typedef logic [PTR_W-1:0] ptr_t;

  logic [PHY_SEL-1:0] mem_q [DEPTH];
  logic [PHY_SEL-1:0] mem_d [DEPTH];
  ptr_t               head_q, head_d;
  ptr_t               tail_q, tail_d;
  ptr_t               chead_q, chead_d;
  logic [CNT_W-1:0]   free_q, free_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;

  function automatic ptr_t wrap_add(input ptr_t p, input int unsigned inc);
    int unsigned s;
    s = (32'(p) + inc) % DEPTH_U;
    return ptr_t'(s);
  endfunction

  assign free_cnt = free_q;

  always_comb begin : p_pop
    pop_pd = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      pop_pd[k*PHY_SEL +: PHY_SEL] = mem_q[wrap_add(head_q, k)];
    end
  end

  // inflight counts allocations not yet committed; on flush they all return to the free pool,
  // which avoids the full/empty ambiguity of comparing tail against the commit head.
  always_comb begin : p_next
    int unsigned      n_push;
    logic [CNT_W-1:0] free_c;
    logic [CNT_W-1:0] inflight_c;
    mem_d  = mem_q;
    n_push = 0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      if (push_valid[k]) begin
        mem_d[wrap_add(tail_q, n_push)] = push_pd[k*PHY_SEL +: PHY_SEL];
        n_push++;
      end
    end
    tail_d     = wrap_add(tail_q, n_push);
    chead_d    = wrap_add(chead_q, n_push);
    free_c     = free_q + CNT_W'(n_push);
    inflight_c = inflight_q - CNT_W'(n_push);
    if (flush) begin
      head_d     = chead_d;
      free_d     = free_c + inflight_c;
      inflight_d = '0;
    end else begin
      head_d     = wrap_add(head_q, 32'(pop_cnt));
      free_d     = free_c - pop_cnt;
      inflight_d = inflight_c + pop_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH_U; i++) begin
        mem_q[i] <= PHY_SEL'(32'(BASE) + i);
      end
      head_q     <= '0;
      tail_q     <= '0;
      chead_q    <= '0;
      free_q     <= CNT_W'(DEPTH);
      inflight_q <= '0;
    end else begin
      mem_q      <= mem_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      chead_q    <= chead_d;
      free_q     <= free_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: rtl/rename_unit_nw.sv
// rename_unit_nw: WIDTH-lane register rename with speculative/committed RATs and flush recovery.
// Optional per-physical-register ready table and rdy1/rdy2 outputs when RENAME_BUSY_EN is defined.
module rename_unit_nw
  import rename_unit_nw_pkg::*;
#(
  parameter int WIDTH     = RENAME_WIDTH,
  parameter int ARCH_REGS = ARCH_REG_CNT,
  parameter int PHY_REGS  = PHY_REG_CNT,
  parameter int ARCH_SEL  = REG_SEL,
  parameter int PHY_SEL   = PHY_REG_SEL
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          lane_valid,
  input  logic [WIDTH*ARCH_SEL-1:0] rs1,
  input  logic [WIDTH*ARCH_SEL-1:0] rs2,
  input  logic [WIDTH*ARCH_SEL-1:0] rd,
  input  logic [WIDTH-1:0]          uses_rs1,
  input  logic [WIDTH-1:0]          uses_rs2,
  input  logic [WIDTH-1:0]          wr_reg,
  output logic [WIDTH*PHY_SEL-1:0]  ps1,
  output logic [WIDTH*PHY_SEL-1:0]  ps2,
  output logic [WIDTH*PHY_SEL-1:0]  pd,
  output logic [WIDTH*PHY_SEL-1:0]  pd_org,
  input  logic [WIDTH-1:0]          com_valid,
  input  logic [WIDTH-1:0]          com_wr_reg,
  input  logic [WIDTH*ARCH_SEL-1:0] com_rd,
  input  logic [WIDTH*PHY_SEL-1:0]  com_pd,
  input  logic [WIDTH*PHY_SEL-1:0]  com_pd_org,
  input  logic                      flush,
`ifdef RENAME_BUSY_EN
  input  logic [WIDTH-1:0]          wb_valid,
  input  logic [WIDTH*PHY_SEL-1:0]  wb_pd,
  output logic [WIDTH-1:0]          rdy1,
  output logic [WIDTH-1:0]          rdy2,
`endif
  output logic                      empty_freelist
);

  localparam int CNT_W = PHY_SEL + 1;
  localparam int DEPTH = PHY_REGS - ARCH_REGS;

  logic [ARCH_SEL-1:0] rs1_a [WIDTH];
  logic [ARCH_SEL-1:0] rs2_a [WIDTH];
  logic [ARCH_SEL-1:0] rd_a [WIDTH];
  logic [ARCH_SEL-1:0] com_rd_a [WIDTH];
  logic [PHY_SEL-1:0]  com_pd_a [WIDTH];
  logic [PHY_SEL-1:0]  pop_a [WIDTH];
  logic [PHY_SEL-1:0]  ps1_a [WIDTH];
  logic [PHY_SEL-1:0]  ps2_a [WIDTH];
  logic [PHY_SEL-1:0]  pd_a [WIDTH];
  logic [PHY_SEL-1:0]  org_a [WIDTH];

  logic [PHY_SEL-1:0]  rat_q [ARCH_REGS];
  logic [PHY_SEL-1:0]  rat_d [ARCH_REGS];
  logic [PHY_SEL-1:0]  arch_q [ARCH_REGS];
  logic [PHY_SEL-1:0]  arch_d [ARCH_REGS];

  logic [WIDTH-1:0]         alloc;
  logic [WIDTH-1:0]         push_valid;
  logic [CNT_W-1:0]         need;
  logic [CNT_W-1:0]         pop_cnt;
  logic [CNT_W-1:0]         free_cnt;
  logic [WIDTH*PHY_SEL-1:0] pop_pd;
  logic                     fire;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    assign rs1_a[g]    = rs1[g*ARCH_SEL +: ARCH_SEL];
    assign rs2_a[g]    = rs2[g*ARCH_SEL +: ARCH_SEL];
    assign rd_a[g]     = rd[g*ARCH_SEL +: ARCH_SEL];
    assign com_rd_a[g] = com_rd[g*ARCH_SEL +: ARCH_SEL];
    assign com_pd_a[g] = com_pd[g*PHY_SEL +: PHY_SEL];
    assign pop_a[g]    = pop_pd[g*PHY_SEL +: PHY_SEL];
    assign push_valid[g] = com_valid[g] & com_wr_reg[g] & (com_rd_a[g] != '0);
    assign ps1[g*PHY_SEL +: PHY_SEL]    = ps1_a[g];
    assign ps2[g*PHY_SEL +: PHY_SEL]    = ps2_a[g];
    assign pd[g*PHY_SEL +: PHY_SEL]     = pd_a[g];
    assign pd_org[g*PHY_SEL +: PHY_SEL] = org_a[g];
  end

  // Lanes are walked oldest first so later lanes see earlier allocations; the last matching
  // earlier lane overwrites, which gives the youngest producer.
  always_comb begin : p_decode
    int unsigned slot;
    slot  = 0;
    alloc = '0;
    for (int unsigned j = 0; j < WIDTH; j++) begin
      alloc[j] = lane_valid[j] & wr_reg[j] & (rd_a[j] != '0);
      pd_a[j]  = '0;
      if (alloc[j]) begin
        for (int unsigned s = 0; s < WIDTH; s++) begin
          if (s == slot) pd_a[j] = pop_a[s];
        end
        slot++;
      end
      ps1_a[j] = rat_q[rs1_a[j]];
      ps2_a[j] = rat_q[rs2_a[j]];
      org_a[j] = rat_q[rd_a[j]];
      for (int unsigned i = 0; i < j; i++) begin
        if (alloc[i] && rd_a[i] == rs1_a[j]) ps1_a[j] = pd_a[i];
        if (alloc[i] && rd_a[i] == rs2_a[j]) ps2_a[j] = pd_a[i];
        if (alloc[i] && rd_a[i] == rd_a[j])  org_a[j] = pd_a[i];
      end
      if (!uses_rs1[j] || rs1_a[j] == '0) ps1_a[j] = '0;
      if (!uses_rs2[j] || rs2_a[j] == '0) ps2_a[j] = '0;
    end
    need = CNT_W'(slot);
  end

  assign empty_freelist = (free_cnt < need);
  assign in_ready       = !flush && !empty_freelist;
  assign fire           = in_valid && in_ready;
  assign pop_cnt        = fire ? need : '0;

  always_comb begin : p_rat
    arch_d = arch_q;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      if (push_valid[k]) arch_d[com_rd_a[k]] = com_pd_a[k];
    end
    rat_d = rat_q;
    if (flush) begin
      rat_d = arch_d;
    end else if (fire) begin
      for (int unsigned j = 0; j < WIDTH; j++) begin
        if (alloc[j]) rat_d[rd_a[j]] = pd_a[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < ARCH_REGS; r++) begin
        rat_q[r]  <= PHY_SEL'(r);
        arch_q[r] <= PHY_SEL'(r);
      end
    end else begin
      rat_q  <= rat_d;
      arch_q <= arch_d;
    end
  end

  rename_freelist #(
    .WIDTH   (WIDTH),
    .PHY_SEL (PHY_SEL),
    .BASE    (ARCH_REGS),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W)
  ) u_freelist (
    .clk        (clk),
    .reset      (reset),
    .pop_cnt    (pop_cnt),
    .push_valid (push_valid),
    .push_pd    (com_pd_org),
    .flush      (flush),
    .pop_pd     (pop_pd),
    .free_cnt   (free_cnt)
  );

`ifdef RENAME_BUSY_EN
  logic [PHY_REGS-1:0] ready_q, ready_d;
  logic [PHY_SEL-1:0]  wb_pd_a [WIDTH];

  for (genvar g = 0; g < WIDTH; g++) begin : g_wb
    assign wb_pd_a[g] = wb_pd[g*PHY_SEL +: PHY_SEL];
  end

  always_comb begin : p_ready
    ready_d = ready_q;
    if (flush) begin
      ready_d = '1;
    end else begin
      if (fire) begin
        for (int unsigned j = 0; j < WIDTH; j++) begin
          if (alloc[j]) ready_d[pd_a[j]] = 1'b0;
        end
      end
      for (int unsigned k = 0; k < WIDTH; k++) begin
        if (wb_valid[k]) ready_d[wb_pd_a[k]] = 1'b1;
      end
    end
  end

  always_comb begin : p_rdy
    logic b1, b2;
    b1   = 1'b0;
    b2   = 1'b0;
    rdy1 = '0;
    rdy2 = '0;
    for (int unsigned j = 0; j < WIDTH; j++) begin
      b1 = 1'b0;
      b2 = 1'b0;
      for (int unsigned i = 0; i < j; i++) begin
        if (alloc[i] && rd_a[i] == rs1_a[j]) b1 = 1'b1;
        if (alloc[i] && rd_a[i] == rs2_a[j]) b2 = 1'b1;
      end
      rdy1[j] = (!uses_rs1[j] || rs1_a[j] == '0) ? 1'b1 : (b1 ? 1'b0 : ready_q[ps1_a[j]]);
      rdy2[j] = (!uses_rs2[j] || rs2_a[j] == '0) ? 1'b1 : (b2 ? 1'b0 : ready_q[ps2_a[j]]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ready_q <= '1;
    else       ready_q <= ready_d;
  end
`endif

endmodule

// File: tb/tb_rename_unit_nw.sv
// Directed self-checking bench for rename_unit_nw (WIDTH=2, 32 arch regs, 64 phys regs).
module tb_rename_unit_nw;

  localparam int W  = 2;
  localparam int AS = 5;
  localparam int PS = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  lane_valid, uses_rs1, uses_rs2, wr_reg;
  logic [W*AS-1:0] rs1, rs2, rd, com_rd;
  logic [W*PS-1:0] ps1, ps2, pd, pd_org, com_pd, com_pd_org;
  logic [W-1:0]  com_valid, com_wr_reg;
  logic          flush;
  logic          empty_freelist;
`ifdef RENAME_BUSY_EN
  logic [W-1:0]    wb_valid;
  logic [W*PS-1:0] wb_pd;
  logic [W-1:0]    rdy1, rdy2;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rename_unit_nw #(
    .WIDTH     (2),
    .ARCH_REGS (32),
    .PHY_REGS  (64),
    .ARCH_SEL  (5),
    .PHY_SEL   (6)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .lane_valid     (lane_valid),
    .rs1            (rs1),
    .rs2            (rs2),
    .rd             (rd),
    .uses_rs1       (uses_rs1),
    .uses_rs2       (uses_rs2),
    .wr_reg         (wr_reg),
    .ps1            (ps1),
    .ps2            (ps2),
    .pd             (pd),
    .pd_org         (pd_org),
    .com_valid      (com_valid),
    .com_wr_reg     (com_wr_reg),
    .com_rd         (com_rd),
    .com_pd         (com_pd),
    .com_pd_org     (com_pd_org),
    .flush          (flush),
`ifdef RENAME_BUSY_EN
    .wb_valid       (wb_valid),
    .wb_pd          (wb_pd),
    .rdy1           (rdy1),
    .rdy2           (rdy2),
`endif
    .empty_freelist (empty_freelist)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] f_ps1(input int l);
    return 32'(ps1[l*PS +: PS]);
  endfunction
  function automatic logic [31:0] f_ps2(input int l);
    return 32'(ps2[l*PS +: PS]);
  endfunction
  function automatic logic [31:0] f_pd(input int l);
    return 32'(pd[l*PS +: PS]);
  endfunction
  function automatic logic [31:0] f_org(input int l);
    return 32'(pd_org[l*PS +: PS]);
  endfunction

  task automatic clear_in();
    in_valid   = 1'b0;
    lane_valid = '0;
    uses_rs1   = '0;
    uses_rs2   = '0;
    wr_reg     = '0;
    rs1        = '0;
    rs2        = '0;
    rd         = '0;
    com_valid  = '0;
    com_wr_reg = '0;
    com_rd     = '0;
    com_pd     = '0;
    com_pd_org = '0;
    flush      = 1'b0;
`ifdef RENAME_BUSY_EN
    wb_valid   = '0;
    wb_pd      = '0;
`endif
  endtask

  task automatic set_lane(input int l, input int s1, input logic u1, input int s2, input logic u2,
                          input int d, input logic w);
    lane_valid[l]       = 1'b1;
    rs1[l*AS +: AS]     = s1[AS-1:0];
    uses_rs1[l]         = u1;
    rs2[l*AS +: AS]     = s2[AS-1:0];
    uses_rs2[l]         = u2;
    rd[l*AS +: AS]      = d[AS-1:0];
    wr_reg[l]           = w;
  endtask

  task automatic set_com(input int l, input int d, input int p, input int org);
    com_valid[l]          = 1'b1;
    com_wr_reg[l]         = 1'b1;
    com_rd[l*AS +: AS]    = d[AS-1:0];
    com_pd[l*PS +: PS]    = p[PS-1:0];
    com_pd_org[l*PS +: PS] = org[PS-1:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_in();
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();

    // reset state
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_empty", 32'(empty_freelist), 0);
    chk("rst_free_cnt", 32'(dut.free_cnt), 32);
    set_lane(0, 7, 1, 0, 1, 0, 0);
    #1;
    chk("rst_rat7", f_ps1(0), 7);
    chk("rst_x0_src", f_ps2(0), 0);
    clear_in();

    // two independent dests after reset
    set_lane(0, 0, 0, 0, 0, 1, 1);
    set_lane(1, 0, 0, 0, 0, 2, 1);
    in_valid = 1'b1;
    #1;
    chk("t1_in_ready", 32'(in_ready), 1);
    chk("t1_pd0", f_pd(0), 32);
    chk("t1_pd1", f_pd(1), 33);
    chk("t1_org0", f_org(0), 1);
    chk("t1_org1", f_org(1), 2);
    tick();
    clear_in();
    chk("t1_free_cnt", 32'(dut.free_cnt), 30);
    set_lane(0, 1, 1, 0, 0, 0, 0);
    set_lane(1, 2, 1, 0, 0, 0, 0);
    #1;
    chk("t1_rat1", f_ps1(0), 32);
    chk("t1_rat2", f_ps1(1), 33);
    clear_in();

    // intra-group bypass with shared rd
    set_lane(0, 0, 0, 1, 1, 5, 1);
    set_lane(1, 5, 1, 0, 1, 5, 1);
    in_valid = 1'b1;
    #1;
    chk("t2_pd0", f_pd(0), 34);
    chk("t2_pd1", f_pd(1), 35);
    chk("t2_ps2_0", f_ps2(0), 32);
    chk("t2_ps1_1_byp", f_ps1(1), 34);
    chk("t2_ps2_1_x0", f_ps2(1), 0);
    chk("t2_org0", f_org(0), 5);
    chk("t2_org1_byp", f_org(1), 34);
    tick();
    clear_in();
    chk("t2_free_cnt", 32'(dut.free_cnt), 28);
    set_lane(0, 5, 1, 0, 0, 0, 0);
    #1;
    chk("t2_rat5_youngest", f_ps1(0), 35);
    clear_in();

    // third group, then commit the first group together with a flush
    set_lane(0, 0, 0, 0, 0, 3, 1);
    set_lane(1, 0, 0, 0, 0, 4, 1);
    in_valid = 1'b1;
    #1;
    chk("t4_grp3_pd0", f_pd(0), 36);
    chk("t4_grp3_pd1", f_pd(1), 37);
    tick();
    clear_in();
    set_com(0, 1, 32, 1);
    set_com(1, 2, 33, 2);
    flush = 1'b1;
    set_lane(0, 0, 0, 0, 0, 11, 1);
    in_valid = 1'b1;
    #1;
    chk("t4_flush_in_ready", 32'(in_ready), 0);
    tick();
    clear_in();
    chk("t4_free_after_flush", 32'(dut.free_cnt), 32);
    set_lane(0, 5, 1, 0, 0, 0, 0);
    set_lane(1, 3, 1, 0, 0, 0, 0);
    #1;
    chk("t4_rat5_restored", f_ps1(0), 5);
    chk("t4_rat3_restored", f_ps1(1), 3);
    clear_in();
    set_lane(0, 1, 1, 0, 0, 0, 0);
    set_lane(1, 2, 1, 0, 0, 0, 0);
    #1;
    chk("t4_rat1_committed", f_ps1(0), 32);
    chk("t4_rat2_committed", f_ps1(1), 33);
    clear_in();
    set_lane(0, 0, 0, 0, 0, 6, 1);
    set_lane(1, 0, 0, 0, 0, 7, 1);
    in_valid = 1'b1;
    #1;
    chk("t4_reuse_pd0", f_pd(0), 34);
    chk("t4_reuse_pd1", f_pd(1), 35);
    tick();
    clear_in();

    // drain the list; head wraps from index 31 to 0
    for (int k = 0; k < 14; k++) begin
      set_lane(0, 0, 0, 0, 0, 8, 1);
      set_lane(1, 0, 0, 0, 0, 9, 1);
      in_valid = 1'b1;
      #1;
      chk("drain_pd0", f_pd(0), 32'(36 + 2*k));
      chk("drain_pd1", f_pd(1), 32'(37 + 2*k));
      tick();
      clear_in();
    end
    chk("drain_free_cnt", 32'(dut.free_cnt), 2);
    set_lane(0, 0, 0, 0, 0, 10, 1);
    in_valid = 1'b1;
    #1;
    chk("wrap_pd0", f_pd(0), 1);
    tick();
    clear_in();
    chk("t3_free_cnt_1", 32'(dut.free_cnt), 1);

    // two allocations against one free entry: stall, no state change
    set_lane(0, 0, 0, 0, 0, 11, 1);
    set_lane(1, 0, 0, 0, 0, 12, 1);
    in_valid = 1'b1;
    #1;
    chk("t3_empty", 32'(empty_freelist), 1);
    chk("t3_in_ready", 32'(in_ready), 0);
    tick();
    chk("t3_free_unchanged", 32'(dut.free_cnt), 1);
    clear_in();
    set_lane(0, 0, 0, 0, 0, 11, 1);
    set_lane(1, 11, 1, 0, 0, 12, 0);
    in_valid = 1'b1;
    #1;
    chk("t3_one_empty", 32'(empty_freelist), 0);
    chk("t3_one_in_ready", 32'(in_ready), 1);
    chk("t3_one_pd0", f_pd(0), 2);
    chk("t3_nonalloc_pd1", f_pd(1), 0);
    chk("t3_byp_ps1_1", f_ps1(1), 2);
    tick();
    clear_in();
    chk("t3_free_cnt_0", 32'(dut.free_cnt), 0);

    // commit two while renaming two at free_cnt=0: freed regs not usable this cycle
    set_com(0, 6, 34, 6);
    set_com(1, 7, 35, 7);
    set_lane(0, 0, 0, 0, 0, 13, 1);
    set_lane(1, 0, 0, 0, 0, 14, 1);
    in_valid = 1'b1;
    #1;
    chk("t5_stall_in_ready", 32'(in_ready), 0);
    chk("t5_stall_empty", 32'(empty_freelist), 1);
    tick();
    com_valid  = '0;
    com_wr_reg = '0;
    #1;
    chk("t5_free_after_commit", 32'(dut.free_cnt), 2);
    chk("t5_in_ready", 32'(in_ready), 1);
    chk("t5_pd0", f_pd(0), 6);
    chk("t5_pd1", f_pd(1), 7);
    tick();
    clear_in();
    chk("t5_free_cnt_0", 32'(dut.free_cnt), 0);
    set_lane(0, 0, 0, 0, 0, 0, 1);
    in_valid = 1'b1;
    #1;
    chk("rd0_no_alloc_ready", 32'(in_ready), 1);
    chk("rd0_no_alloc_pd", f_pd(0), 0);
    tick();
    clear_in();

    // flush with nothing committing: every uncommitted rename returns
    flush = 1'b1;
    tick();
    clear_in();
    chk("fl2_free_cnt", 32'(dut.free_cnt), 32);
    set_lane(0, 6, 1, 0, 0, 0, 0);
    set_lane(1, 13, 1, 0, 0, 0, 0);
    #1;
    chk("fl2_rat6", f_ps1(0), 34);
    chk("fl2_rat13", f_ps1(1), 13);
    clear_in();
    set_lane(0, 0, 0, 0, 0, 15, 1);
    in_valid = 1'b1;
    #1;
    chk("fl2_next_pd", f_pd(0), 36);
    tick();
    clear_in();

`ifdef RENAME_BUSY_EN
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_lane(0, 0, 0, 0, 0, 2*k + 1, 1);
      set_lane(1, 0, 0, 0, 0, 2*k + 2, 1);
      in_valid = 1'b1;
      tick();
      clear_in();
    end
    set_lane(0, 0, 0, 0, 0, 9, 1);
    set_lane(1, 9, 1, 0, 1, 0, 0);
    in_valid = 1'b1;
    #1;
    chk("busy_pd40", f_pd(0), 40);
    chk("busy_byp_rdy1", 32'(rdy1[1]), 0);
    chk("busy_x0_rdy2", 32'(rdy2[1]), 1);
    tick();
    clear_in();
    set_lane(0, 9, 1, 0, 0, 0, 0);
    set_lane(1, 1, 1, 0, 0, 0, 0);
    #1;
    chk("busy_ps1_40", f_ps1(0), 40);
    chk("busy_rdy_40", 32'(rdy1[0]), 0);
    wb_valid[0]   = 1'b1;
    wb_pd[0 +: PS] = 6'd40;
    tick();
    wb_valid = '0;
    #1;
    chk("busy_rdy_40_wb", 32'(rdy1[0]), 1);
    chk("busy_rdy_32_still", 32'(rdy1[1]), 0);
    clear_in();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
